led_mode_ctrl: RTL and testbench
================================

LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 Parameter LONG_PRESS_CYC, default 50_000_000, hold time in sclk cycles that qualifies a long press (1 s at 50 MHz).
REQ-002 Parameter SLOW_HALF_CYC, default 25_000_000, half-period of slow blink in sclk cycles.
REQ-003 Parameter FAST_HALF_CYC, default 6_250_000, half-period of fast blink in sclk cycles.
REQ-004 sclk  input  1  system clock, all logic on rising edge.
REQ-005 s_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 key_flag  input  1  one-cycle pulse from debouncer marking a qualified press.
REQ-007 key_state  input  1  debounced key level, 0 = pressed, 1 = released.
REQ-008 led  output  1  LED drive, 1 = lit.
REQ-009 mode  output  2  current mode: 0 OFF, 1 ON, 2 SLOW, 3 FAST.
REQ-010 long_evt  output  1  one-cycle pulse on long-press detection.

Function
REQ-011 Press FSM SHALL have states IDLE, PRESSED, LONG_HELD.
REQ-012 IDLE -> PRESSED on key_flag=1; hold counter cleared to 0 on entry.
REQ-013 PRESSED: hold counter increments each cycle while key_state=0, saturating at LONG_PRESS_CYC.
REQ-014 PRESSED -> IDLE on key_state=1 with hold counter < LONG_PRESS_CYC; this is a short press.
REQ-015 Short press SHALL advance mode by 1 modulo 4 (3 wraps to 0) in the cycle after release is seen.
REQ-016 PRESSED -> LONG_HELD when hold counter reaches LONG_PRESS_CYC-1 with key_state=0; long_evt=1 for that one cycle; mode forced to 0 next cycle.
REQ-017 LONG_HELD -> IDLE on key_state=1; release SHALL NOT change mode.
REQ-018 key_flag received outside IDLE SHALL be ignored.
REQ-019 Short-press release and a new key_flag in the same cycle: release is processed, key_flag ignored.
REQ-020 led: mode 0 -> 0, mode 1 -> 1, modes 2/3 -> toggle every SLOW_HALF_CYC / FAST_HALF_CYC cycles.
REQ-021 Blink counter SHALL clear and led SHALL be 1 in the first cycle of any mode change into 2 or 3.
REQ-022 Blink counter counts 0..HALF_CYC-1, toggles led at terminal count and wraps to 0.
REQ-023 Counter widths SHALL be $clog2 of the largest count plus 1; no overflow at any parameter value >= 2.
REQ-024 All outputs registered; mode and led change 1 cycle after the triggering condition.

Reset
REQ-025 Asserting s_rst_n=0 SHALL immediately force: FSM IDLE, mode=0, led=0, long_evt=0, all counters 0.
REQ-026 Reset mid-press: after deassertion the FSM SHALL stay in IDLE until a new key_flag, even with key_state=0.
REQ-027 Reset deassertion needs no synchronisation inside the block; upstream provides a synchronised release.

Configuration
REQ-028 Macro LED_MODE_LONG_PRESS_EN SHALL compile long-press detection in.
REQ-029 With LED_MODE_LONG_PRESS_EN defined: behaviour per REQ-013..REQ-017.
REQ-030 Without it: no hold counter, no LONG_HELD state, long_evt tied to 0, every release counts as a short press regardless of hold time.

Verification (bench with LONG_PRESS_CYC=300, SLOW_HALF_CYC=20, FAST_HALF_CYC=5)
REQ-031 Reset release, no key activity for 1000 cycles -> mode=0, led=0, long_evt never 1.
REQ-032 Four short presses (key_flag, key_state=0 for 100 cycles, release) -> mode 1,2,3,0; led 1, blink period 40, blink period 10, 0.
REQ-033 From mode 2, hold 400 cycles -> long_evt single pulse at cycle 300 of hold, mode=0 next cycle, unchanged after release.
REQ-034 Mode 3 with key_flag pulses injected during PRESSED -> ignored, exactly one mode advance per press.
REQ-035 s_rst_n pulled low at hold cycle 150 then released with key still low -> mode=0, FSM IDLE, no event until next key_flag.
REQ-036 Build without LED_MODE_LONG_PRESS_EN, hold 400 cycles from mode 1 -> long_evt stays 0, mode=2 after release.

Source files
------------

// File: rtl/led_mode_ctrl.sv
//------------------------------------------------------------------------------
// Module      : led_mode_ctrl
// Description : Single-key LED mode controller. A short press cycles the
//               mode OFF -> ON -> SLOW blink -> FAST blink -> OFF. A long
//               press forces the mode to OFF and emits a one-cycle long_evt.
//               Long-press detection is compiled in only when the macro
//               LED_MODE_LONG_PRESS_EN is defined; without it every release
//               counts as a short press and long_evt is held at 0.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module led_mode_ctrl #(
    parameter int LONG_PRESS_CYC = 50_000_000,
    parameter int SLOW_HALF_CYC  = 25_000_000,
    parameter int FAST_HALF_CYC  = 6_250_000
) (
    input  logic       sclk,
    input  logic       s_rst_n,
    input  logic       key_flag,
    input  logic       key_state,
    output logic       led,
    output logic [1:0] mode,
    output logic       long_evt
);

    // Blink counter is sized for the larger half-period plus one spare bit.
    localparam int c_MAX_HALF = (SLOW_HALF_CYC > FAST_HALF_CYC) ? SLOW_HALF_CYC : FAST_HALF_CYC;
    localparam int c_BLINK_W  = $clog2(c_MAX_HALF) + 1;
    localparam logic [c_BLINK_W-1:0] c_SLOW_TC = c_BLINK_W'(SLOW_HALF_CYC - 1);
    localparam logic [c_BLINK_W-1:0] c_FAST_TC = c_BLINK_W'(FAST_HALF_CYC - 1);

`ifdef LED_MODE_LONG_PRESS_EN
    localparam int c_HOLD_W = $clog2(LONG_PRESS_CYC) + 1;
    localparam logic [c_HOLD_W-1:0] c_HOLD_TC  = c_HOLD_W'(LONG_PRESS_CYC - 1);
    localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_PRESS_CYC);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_PRESSED   = 2'd1,
        ST_LONG_HELD = 2'd2
    } state_t;

    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic                r_long_evt;
    logic                w_long_det;
`else
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_PRESSED = 1'b1
    } state_t;
`endif

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 w_short;
    logic                 w_long_pulse;
    logic [1:0]           r_mode;
    logic [1:0]           w_mode_nxt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 w_blink_tc;
    logic                 r_led;

    // Press FSM state register; reset drops any press in progress.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Press FSM next state; key_flag only matters in IDLE, so a flag that
    // coincides with a release is dropped.
    always_comb begin
        w_state_nxt = r_state;
        w_short     = 1'b0;
`ifdef LED_MODE_LONG_PRESS_EN
        w_long_det  = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (key_flag) begin
                    w_state_nxt = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                // The hold counter never reaches LONG_PRESS_CYC while in
                // PRESSED, so any release here is a short press.
                if (key_state) begin
                    w_short     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
`ifdef LED_MODE_LONG_PRESS_EN
                else if (r_hold_cnt == c_HOLD_TC) begin
                    w_long_det  = 1'b1;
                    w_state_nxt = ST_LONG_HELD;
                end
            end
            ST_LONG_HELD: begin
                if (key_state) begin
                    w_state_nxt = ST_IDLE;
                end
`endif
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

`ifdef LED_MODE_LONG_PRESS_EN
    // Hold counter: cleared on press entry, counts low-key cycles, saturates.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_hold_cnt <= '0;
        end else if ((r_state == ST_IDLE) && key_flag) begin
            r_hold_cnt <= '0;
        end else if ((r_state == ST_PRESSED) && !key_state && (r_hold_cnt != c_HOLD_MAX)) begin
            r_hold_cnt <= r_hold_cnt + c_HOLD_W'(1);
        end
    end

    // Long-press event register: one pulse on the detection cycle.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_long_evt <= 1'b0;
        end else begin
            r_long_evt <= w_long_det;
        end
    end

    assign w_long_pulse = r_long_evt;
`else
    assign w_long_pulse = 1'b0;
`endif

    // Next mode: the long-press pulse clears the mode one cycle after it is
    // raised; a short press advances it with natural 2-bit wrap.
    always_comb begin
        w_mode_nxt = r_mode;
        if (w_long_pulse) begin
            w_mode_nxt = 2'd0;
        end else if (w_short) begin
            w_mode_nxt = r_mode + 2'd1;
        end
    end

    // Mode register.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_mode <= 2'd0;
        end else begin
            r_mode <= w_mode_nxt;
        end
    end

    assign w_blink_tc = (r_mode == 2'd2) ? (r_blink_cnt == c_SLOW_TC) : (r_blink_cnt == c_FAST_TC);

    // LED driver: restart the blink phase lit on every mode change, then
    // hold steady (OFF/ON) or toggle at the blink terminal count.
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
        end else if (w_mode_nxt != r_mode) begin
            r_blink_cnt <= '0;
            r_led       <= (w_mode_nxt != 2'd0);
        end else if (r_mode == 2'd0) begin
            r_blink_cnt <= '0;
            r_led       <= 1'b0;
        end else if (r_mode == 2'd1) begin
            r_blink_cnt <= '0;
            r_led       <= 1'b1;
        end else if (w_blink_tc) begin
            r_blink_cnt <= '0;
            r_led       <= ~r_led;
        end else begin
            r_blink_cnt <= r_blink_cnt + c_BLINK_W'(1);
        end
    end

    assign led      = r_led;
    assign mode     = r_mode;
    assign long_evt = w_long_pulse;

endmodule

`default_nettype wire

// File: tb/tb_led_mode_ctrl.sv
//------------------------------------------------------------------------------
// Module      : tb_led_mode_ctrl
// Description : Scoreboard bench for led_mode_ctrl. Stimulus tasks update a
//               behavioural model at each clock edge and queue the expected
//               outputs; a monitor pops and compares on the falling edge.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_led_mode_ctrl;

    localparam int LONG = 300;
    localparam int SLOW = 20;
    localparam int FAST = 5;
`ifdef LED_MODE_LONG_PRESS_EN
    localparam bit LP_EN = 1'b1;
`else
    localparam bit LP_EN = 1'b0;
`endif

    logic       sclk      = 1'b0;
    logic       s_rst_n   = 1'b0;
    logic       key_flag  = 1'b0;
    logic       key_state = 1'b1;
    logic       led;
    logic [1:0] mode;
    logic       long_evt;

    led_mode_ctrl #(
        .LONG_PRESS_CYC (LONG),
        .SLOW_HALF_CYC  (SLOW),
        .FAST_HALF_CYC  (FAST)
    ) dut (
        .sclk      (sclk),
        .s_rst_n   (s_rst_n),
        .key_flag  (key_flag),
        .key_state (key_state),
        .led       (led),
        .mode      (mode),
        .long_evt  (long_evt)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [1:0] mode;
        logic       led;
        logic       evt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: a press in progress, how long it has been held,
    // whether it already became long, and how long the current mode has run.
    int m_mode = 0;
    bit m_busy = 0;
    bit m_long = 0;
    int m_held = 0;
    bit m_evt  = 0;
    int m_age  = 0;

    function automatic logic model_led(input int md, input int age);
        case (md)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ((age / SLOW) % 2) == 0;
            default: return ((age / FAST) % 2) == 0;
        endcase
    endfunction

    task automatic model_edge(input bit rst_n, input bit f, input bit s);
        int   nm;
        bit   ev;
        exp_t e;
        if (!rst_n) begin
            m_mode = 0; m_busy = 0; m_long = 0; m_held = 0; m_evt = 0; m_age = 0;
        end else begin
            nm = m_mode;
            ev = 0;
            if (m_evt) nm = 0;
            if (!m_busy) begin
                if (f) begin
                    m_busy = 1; m_long = 0; m_held = 0;
                end
            end else if (s) begin
                if (!m_long) nm = (m_mode + 1) % 4;
                m_busy = 0;
            end else if (!m_long) begin
                m_held++;
                if (LP_EN && m_held == LONG) begin
                    ev = 1; m_long = 1;
                end
            end
            m_age  = (nm != m_mode) ? 0 : m_age + 1;
            m_mode = nm;
            m_evt  = ev;
        end
        e.mode = 2'(m_mode);
        e.led  = model_led(m_mode, m_age);
        e.evt  = m_evt;
        exp_q.push_back(e);
    endtask

    // One clock cycle with the given reset, flag and key level.
    task automatic step(input bit r, input bit f, input bit s);
        bit falling;
        @(negedge sclk);
        #1;
        falling   = s_rst_n && !r;
        s_rst_n   = r;
        key_flag  = f;
        key_state = s;
        if (falling) begin
            #1;
            n_checks++;
            if ({mode, led, long_evt} !== 4'b0000) begin
                n_fail++;
                $display("FAIL async_reset: got mode=%0d led=%0b long_evt=%0b, want all 0",
                         mode, led, long_evt);
            end
        end
        @(posedge sclk);
        model_edge(r, f, s);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1);
    endtask

    // Press: flag cycle, then hold-1 low cycles with random stray flags,
    // then a release (optionally carrying a stray flag too).
    task automatic press(input int hold, input int flag_pct);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < hold - 1; i++)
            step(1'b1, $urandom_range(99) < flag_pct, 1'b0);
        step(1'b1, (flag_pct > 0) && ($urandom_range(1) == 1), 1'b1);
    endtask

    task automatic goto_mode(input int target);
        for (int i = 0; i < 8 && m_mode != target; i++) begin
            press(20, 0);
            idle(5);
        end
    endtask

    // Scoreboard monitor: one expected entry per clock edge.
    always @(negedge sclk) begin : mon
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({mode, led, long_evt} !== e) begin
                n_fail++;
                $display("FAIL outputs t=%0t: got mode=%0d led=%0b long_evt=%0b, want mode=%0d led=%0b long_evt=%0b",
                         $time, mode, led, long_evt, e.mode, e.led, e.evt);
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, want end of test");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        // Reset held, then quiet key for 1000 cycles.
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(1000);

        // Four short presses walk through all modes with blinking observed.
        for (int k = 0; k < 4; k++) begin
            press(101, 0);
            idle(100);
        end

        // Long hold from SLOW mode.
        goto_mode(2);
        idle(50);
        press(401, 0);
        idle(60);

        // Stray flags during a press from FAST mode.
        goto_mode(3);
        idle(10);
        press(100, 15);
        idle(30);

        // Reset in the middle of a hold, key still down after release.
        goto_mode(2);
        step(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 150; i++) step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 400; i++) step(1'b1, 1'b0, 1'b0);
        idle(20);

        // Long hold from ON mode.
        goto_mode(1);
        idle(10);
        press(401, 0);
        idle(50);

        // Randomised presses, lengths straddling the long-press threshold.
        for (int k = 0; k < 30; k++) begin
            press($urandom_range(420, 1), $urandom_range(20, 0));
            idle($urandom_range(60, 0));
        end

        @(negedge sclk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
